// File: rtl/det_pkg.sv
// Shared constants for the Detector perceptron stage.
package det_pkg;

  localparam int DET_WIDTH = 16;

endpackage : det_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule : full_subtractor

// File: rtl/eq_sub_recognition.sv
// Pattern recogniser: ripple-borrow subtract in - weight, flag a zero difference,
// register the flag with an asynchronous clear.
module eq_sub_recognition
  import det_pkg::*;
#(
  parameter int WIDTH = DET_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] weight,
  output logic             recognition
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;
  logic             match_d;
  logic             recognition_q;
  logic             borrow_out_unused;

  assign borrow[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_sub
      full_subtractor u_fs (
        .a    (in[g]),
        .b    (weight[g]),
        .bin  (borrow[g]),
        .d    (diff[g]),
        .bout (borrow[g+1])
      );
    end
  endgenerate

  // A wrapped subtraction still leaves a nonzero diff, so the final borrow adds nothing.
  assign borrow_out_unused = borrow[WIDTH];

  assign match_d = ~|diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recognition_q <= 1'b0;
    end else begin
      recognition_q <= match_d;
    end
  end

  assign recognition = recognition_q;

endmodule : eq_sub_recognition

// File: tb/tb_eq_sub_recognition.sv
// Self-checking bench for eq_sub_recognition: vector table, reset sequences, random pairs.
module tb_eq_sub_recognition;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic [W-1:0] weight;
  logic         recognition;

  int n_checks = 0;
  int n_errors = 0;

  eq_sub_recognition #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .weight      (weight),
    .recognition (recognition)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: recognition=%b expected=%b (in=%h weight=%h)", name, act, exp, in, weight);
    end
  endtask

  // Reference: registered result is simply whether the operands were equal before the edge.
  function automatic logic ref_match(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == b);
  endfunction

  task automatic apply(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in     = a;
    weight = b;
    @(posedge clk);
    #1;
    check(name, recognition, ref_match(a, b));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;

    vecs[0] = '{"equal_pattern",   16'b1110010001000100, 16'b1110010001000100, 1'b1};
    vecs[1] = '{"msb_region_diff", 16'b0100010001000100, 16'b1110010001000100, 1'b0};
    vecs[2] = '{"upper_bits_diff", 16'b1111110001000100, 16'b1110010001000100, 1'b0};
    vecs[3] = '{"ones_vs_weight",  16'hFFFF,             16'b1110010001000100, 1'b0};
    vecs[4] = '{"swapped_ones",    16'b1111110001000100, 16'hFFFF,             1'b0};
    vecs[5] = '{"all_ones",        16'hFFFF,             16'hFFFF,             1'b1};
    vecs[6] = '{"all_zeros",       16'h0000,             16'h0000,             1'b1};
    vecs[7] = '{"wrap_0_minus_1",  16'h0000,             16'h0001,             1'b0};
    vecs[8] = '{"msb_only_diff",   16'h8000,             16'h0000,             1'b0};

    rst_n  = 1'b0;
    in     = 16'h1234;
    weight = 16'h1234;
    #2;
    check("reset_async_low", recognition, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_holds_with_match", recognition, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_before_edge", recognition, 1'b0);
    @(posedge clk);
    #1;
    check("first_edge_after_release", recognition, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      in     = vecs[i].a;
      weight = vecs[i].b;
      @(posedge clk);
      #1;
      check(vecs[i].name, recognition, vecs[i].exp);
    end

    // Latency: a change just after an edge must not show until the following edge.
    apply("latency_setup_match", 16'hA5A5, 16'hA5A5);
    @(negedge clk);
    in = 16'hA5A4;
    #1;
    check("latency_hold_old", recognition, 1'b1);
    @(posedge clk);
    #1;
    check("latency_new_value", recognition, 1'b0);

    // Mid-operation reset pulse between edges while a match is held.
    apply("midreset_setup", 16'h3C3C, 16'h3C3C);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_async_clear", recognition, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    check("midreset_no_edge_yet", recognition, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_recover", recognition, 1'b1);

    for (int i = 0; i < W; i++) begin
      ra = W'($urandom);
      rb = ra ^ (W'(1) << i);
      apply($sformatf("single_bit_%0d", i), ra, rb);
    end

    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 3);
      ra  = W'($urandom);
      if (sel == 0) rb = ra;
      else if (sel == 1) rb = ra ^ (W'(1) << $urandom_range(0, W-1));
      else rb = W'($urandom);
      apply($sformatf("random_%0d", i), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_eq_sub_recognition
